// File: rtl/pulse_train_gen_pkg.sv
// Shared definitions for the pulse train generator: FSM state encoding and
// default field widths used by pulse_train_gen and its sub-modules.
package pulse_train_gen_pkg;

    // Default width of the delay, width and period timing fields (clock cycles).
    localparam int PTG_CNT_W_DEF = 16;

    // Default width of the pulse-count field.
    localparam int PTG_NUM_W_DEF = 8;

    // Train sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } ptg_state_e;

endpackage : pulse_train_gen_pkg

// File: rtl/pulse_train_gen_trig_edge_det.sv
// Trigger edge detector for pulse_train_gen.
// Registers the raw trigger and flags the cycle in which it goes from 0 to 1.
// The registered level resets to 0, so a trigger that is already high when
// reset releases is seen as a rising edge at the first clock edge.
module trig_edge_det
    import pulse_train_gen_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic trig_i,
    output logic rise_o
);

    logic trig_q;

    // Hold last cycle's trigger level so only a 0->1 transition is reported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_q <= 1'b0;
        end else begin
            trig_q <= trig_i;
        end
    end

    assign rise_o = trig_i & ~trig_q;

endmodule : trig_edge_det

// File: rtl/pulse_train_gen.sv
// Pulse train generator.
// On an accepted trigger rising edge, waits D cycles, then emits N pulses of
// effective width We = max(W,1) spaced by effective period Pe = max(P,We+1).
// The output is registered one cycle behind the HIGH state, so a pulse
// appears at the edge after the FSM enters HIGH. Configuration is latched at
// acceptance. Abort cancels a running train with no done strobe.
//
// Build option: PULSE_TRAIN_GEN_CONTINUOUS_EN
//   defined   -> N=0 gives an endless train (ended only by abort/reset).
//   undefined -> N=0 gives no pulse, a one-cycle busy and a done strobe.
module pulse_train_gen
    import pulse_train_gen_pkg::*;
#(
    parameter int CNT_W = PTG_CNT_W_DEF,
    parameter int NUM_W = PTG_NUM_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trig,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [NUM_W-1:0] cfg_count,
    output logic             out,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [NUM_W-1:0] NUM_ZERO = {NUM_W{1'b0}};
    localparam logic [NUM_W-1:0] NUM_ONE  = {{(NUM_W-1){1'b0}}, 1'b1};

`ifdef PULSE_TRAIN_GEN_CONTINUOUS_EN
    localparam logic CONT_EN = 1'b1;
`else
    localparam logic CONT_EN = 1'b0;
`endif

    // Effective high time: a zero width still produces a one-cycle pulse.
    function automatic logic [CNT_W-1:0] eff_width(input logic [CNT_W-1:0] w);
        if (w == CNT_ZERO) begin
            return CNT_ONE;
        end else begin
            return w;
        end
    endfunction

    // Low time between pulses, Pe - We. Since Pe = max(P, We+1) the result is
    // P - We when P exceeds We and 1 otherwise; computed without forming We+1
    // so a maximum-value width cannot overflow the field.
    function automatic logic [CNT_W-1:0] low_len(input logic [CNT_W-1:0] we,
                                                 input logic [CNT_W-1:0] p);
        if (p > we) begin
            return p - we;
        end else begin
            return CNT_ONE;
        end
    endfunction

    // Pulse-count decrement that holds at zero instead of wrapping.
    function automatic logic [NUM_W-1:0] dec_sat(input logic [NUM_W-1:0] n);
        if (n == NUM_ZERO) begin
            return NUM_ZERO;
        end else begin
            return n - NUM_ONE;
        end
    endfunction

    ptg_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;    // cycles left in current state
    logic [NUM_W-1:0] rem_q,   rem_d;    // pulses not yet started
    logic [CNT_W-1:0] we_q,    we_d;     // latched effective width
    logic [CNT_W-1:0] low_q,   low_d;    // latched low time between pulses
    logic             cont_q,  cont_d;   // endless train in progress
    logic             out_q,   out_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    logic trig_rise_s;
    logic accept_s;

    trig_edge_det u_trig_edge_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .trig_i (trig),
        .rise_o (trig_rise_s)
    );

    assign accept_s = trig_rise_s & ~busy_q;

    // Sequencer: next state, counters and registered-output values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        we_d    = we_q;
        low_d   = low_q;
        cont_d  = cont_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        out_d   = (state_q == ST_HIGH);

        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
            rem_d   = NUM_ZERO;
            cont_d  = 1'b0;
            busy_d  = 1'b0;
            out_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        busy_d = 1'b1;
                        we_d   = eff_width(cfg_width);
                        low_d  = low_len(eff_width(cfg_width), cfg_period);
                        cont_d = CONT_EN && (cfg_count == NUM_ZERO);
                        if ((cfg_count == NUM_ZERO) && !CONT_EN) begin
                            // Empty train: one LOW cycle, then finish with done.
                            state_d = ST_LOW;
                            cnt_d   = CNT_ONE;
                            rem_d   = NUM_ZERO;
                        end else if (cfg_delay != CNT_ZERO) begin
                            state_d = ST_DELAY;
                            cnt_d   = cfg_delay;
                            rem_d   = cfg_count;
                        end else begin
                            state_d = ST_HIGH;
                            cnt_d   = eff_width(cfg_width);
                            rem_d   = dec_sat(cfg_count);
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end

                ST_DELAY: begin
                    if (cnt_q <= CNT_ONE) begin
                        state_d = ST_HIGH;
                        cnt_d   = we_q;
                        rem_d   = dec_sat(rem_q);
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end

                ST_HIGH: begin
                    if (cnt_q <= CNT_ONE) begin
                        state_d = ST_LOW;
                        // After the last pulse, LOW lasts one cycle so busy drops
                        // on the same edge the output clears.
                        if ((rem_q != NUM_ZERO) || cont_q) begin
                            cnt_d = low_q;
                        end else begin
                            cnt_d = CNT_ONE;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end

                ST_LOW: begin
                    if (cnt_q <= CNT_ONE) begin
                        if ((rem_q != NUM_ZERO) || cont_q) begin
                            state_d = ST_HIGH;
                            cnt_d   = we_q;
                            rem_d   = dec_sat(rem_q);
                        end else begin
                            state_d = ST_IDLE;
                            cnt_d   = CNT_ZERO;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                    rem_d   = NUM_ZERO;
                    cont_d  = 1'b0;
                    busy_d  = 1'b0;
                    out_d   = 1'b0;
                end
            endcase
        end
    end

    // State, counters and outputs; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            rem_q   <= NUM_ZERO;
            we_q    <= CNT_ZERO;
            low_q   <= CNT_ZERO;
            cont_q  <= 1'b0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            we_q    <= we_d;
            low_q   <= low_d;
            cont_q  <= cont_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule : pulse_train_gen

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen. Expected waveforms come from a
// closed-form model of the pulse timing (edge offsets relative to the
// acceptance edge). Honours PULSE_TRAIN_GEN_CONTINUOUS_EN for the N=0 case.
module tb_pulse_train_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trig;
    logic        abort;
    logic [15:0] cfg_delay;
    logic [15:0] cfg_width;
    logic [15:0] cfg_period;
    logic [7:0]  cfg_count;
    logic        out;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    pulse_train_gen #(.CNT_W(16), .NUM_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trig       (trig),
        .abort      (abort),
        .cfg_delay  (cfg_delay),
        .cfg_width  (cfg_width),
        .cfg_period (cfg_period),
        .cfg_count  (cfg_count),
        .out        (out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic int eff_w(input int w);
        if (w < 1) return 1;
        else return w;
    endfunction

    function automatic int eff_p(input int w, input int p);
        int we;
        we = eff_w(w);
        if (p < we + 1) return we + 1;
        else return p;
    endfunction

    // Expected out after edge k+t: pulse i is high for edges [1+D+i*Pe, 1+D+i*Pe+We).
    function automatic bit m_out(input int t, input int d, input int w,
                                 input int p, input int n, input bit endless);
        int rel;
        int we;
        int pe;
        we  = eff_w(w);
        pe  = eff_p(w, p);
        rel = t - 1 - d;
        if (rel < 0) return 1'b0;
        if (!endless && ((rel / pe) >= n)) return 1'b0;
        return (rel % pe) < we;
    endfunction

    // Edge offset at which busy falls (done is high in the following cycle).
    function automatic int m_end(input int d, input int w, input int p, input int n);
        if (n == 0) return 1;
        return 1 + d + (n - 1) * eff_p(w, p) + eff_w(w);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        trig       = 1'b0;
        abort      = 1'b0;
        cfg_delay  = 16'd0;
        cfg_width  = 16'd0;
        cfg_period = 16'd0;
        cfg_count  = 8'd0;
        #1;
        n_checks++;
        if ({out, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_initial out/busy/done got %b%b%b expected 000", out, busy, done);
        end
        repeat (2) tick();
        n_checks++;
        if ({out, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_held out/busy/done got %b%b%b expected 000", out, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({out, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_release out/busy/done got %b%b%b expected 000", out, busy, done);
        end
    endtask

    // Run one train and compare every cycle; with disturb, a second trigger
    // edge and new cfg values are applied mid-train and must change nothing.
    task automatic test_train(input string name, input int d, input int w,
                              input int p, input int n, input bit disturb);
        int endt;
        bit eo;
        cfg_delay  = 16'(d);
        cfg_width  = 16'(w);
        cfg_period = 16'(p);
        cfg_count  = 8'(n);
        endt       = m_end(d, w, p, n);
        trig = 1'b0;
        tick();
        trig = 1'b1;
        tick();
        for (int t = 0; t <= endt + 1; t++) begin
            eo = m_out(t, d, w, p, n, 1'b0);
            n_checks++;
            if (out !== eo) begin
                n_fail++;
                $display("FAIL %s_out t=%0d got %b expected %b", name, t, out, eo);
            end
            n_checks++;
            if (busy !== (t < endt)) begin
                n_fail++;
                $display("FAIL %s_busy t=%0d got %b expected %b", name, t, busy, (t < endt));
            end
            n_checks++;
            if (done !== (t == endt)) begin
                n_fail++;
                $display("FAIL %s_done t=%0d got %b expected %b", name, t, done, (t == endt));
            end
            if (disturb && (t == 2)) begin
                trig       = 1'b1;
                cfg_delay  = 16'($urandom_range(0, 9));
                cfg_width  = 16'($urandom_range(0, 9));
                cfg_period = 16'($urandom_range(0, 9));
                cfg_count  = 8'($urandom_range(0, 5));
            end else begin
                trig = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_random();
        int d;
        int w;
        int p;
        int n;
        for (int i = 0; i < 8; i++) begin
            d = int'($urandom_range(0, 4));
            w = int'($urandom_range(0, 5));
            p = int'($urandom_range(0, 9));
            n = int'($urandom_range(1, 4));
            test_train("random", d, w, p, n, m_end(d, w, p, n) > 4);
        end
    endtask

    task automatic test_abort();
        cfg_delay  = 16'd1;
        cfg_width  = 16'd3;
        cfg_period = 16'd6;
        cfg_count  = 8'd4;
        trig = 1'b0;
        tick();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        for (int t = 0; t <= 8; t++) begin
            n_checks++;
            if (out !== m_out(t, 1, 3, 6, 4, 1'b0)) begin
                n_fail++;
                $display("FAIL abort_pre_out t=%0d got %b expected %b", t, out, m_out(t, 1, 3, 6, 4, 1'b0));
            end
            if (t < 8) tick();
        end
        abort = 1'b1;
        trig  = 1'b1;
        tick();
        abort = 1'b0;
        trig  = 1'b0;
        n_checks++;
        if ({out, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_edge out/busy/done got %b%b%b expected 000", out, busy, done);
        end
        for (int t = 0; t < 4; t++) begin
            tick();
            n_checks++;
            if ({out, busy, done} !== 3'b000) begin
                n_fail++;
                $display("FAIL abort_after t=%0d out/busy/done got %b%b%b expected 000", t, out, busy, done);
            end
        end
        test_train("after_abort", 1, 3, 6, 2, 1'b0);
    endtask

    task automatic test_async_reset();
        int endt;
        bit eo;
        cfg_delay  = 16'd0;
        cfg_width  = 16'd4;
        cfg_period = 16'd8;
        cfg_count  = 8'd2;
        endt = m_end(0, 4, 8, 2);
        trig = 1'b0;
        tick();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        tick();
        tick();
        n_checks++;
        if (out !== 1'b1) begin
            n_fail++;
            $display("FAIL async_pre_out got %b expected 1", out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL async_reset_now out/busy/done got %b%b%b expected 000", out, busy, done);
        end
        trig = 1'b1;
        tick();
        n_checks++;
        if ({out, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL async_reset_held out/busy/done got %b%b%b expected 000", out, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        trig = 1'b0;
        for (int t = 0; t <= endt + 1; t++) begin
            eo = m_out(t, 0, 4, 8, 2, 1'b0);
            n_checks++;
            if (out !== eo) begin
                n_fail++;
                $display("FAIL trig_through_reset_out t=%0d got %b expected %b", t, out, eo);
            end
            n_checks++;
            if (busy !== (t < endt)) begin
                n_fail++;
                $display("FAIL trig_through_reset_busy t=%0d got %b expected %b", t, busy, (t < endt));
            end
            n_checks++;
            if (done !== (t == endt)) begin
                n_fail++;
                $display("FAIL trig_through_reset_done t=%0d got %b expected %b", t, done, (t == endt));
            end
            tick();
        end
    endtask

    task automatic test_zero_count();
`ifdef PULSE_TRAIN_GEN_CONTINUOUS_EN
        int  pulses;
        bit  prev;
        bit  eo;
        pulses = 0;
        prev   = 1'b0;
        cfg_delay  = 16'd0;
        cfg_width  = 16'd1;
        cfg_period = 16'd4;
        cfg_count  = 8'd0;
        trig = 1'b0;
        tick();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        for (int t = 0; t <= 40; t++) begin
            eo = m_out(t, 0, 1, 4, 0, 1'b1);
            n_checks++;
            if (out !== eo) begin
                n_fail++;
                $display("FAIL cont_out t=%0d got %b expected %b", t, out, eo);
            end
            n_checks++;
            if ({busy, done} !== 2'b10) begin
                n_fail++;
                $display("FAIL cont_busy_done t=%0d got %b%b expected 10", t, busy, done);
            end
            if (out && !prev) pulses++;
            prev = out;
            if (t < 40) tick();
        end
        n_checks++;
        if (pulses != 10) begin
            n_fail++;
            $display("FAIL cont_pulse_count got %0d expected 10", pulses);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int t = 0; t < 6; t++) begin
            n_checks++;
            if ({out, busy, done} !== 3'b000) begin
                n_fail++;
                $display("FAIL cont_abort t=%0d out/busy/done got %b%b%b expected 000", t, out, busy, done);
            end
            tick();
        end
`else
        test_train("zero_count", 2, 3, 5, 0, 1'b0);
`endif
    endtask

    initial begin
        test_reset();
        test_train("d2_w3_p10_n3", 2, 3, 10, 3, 1'b0);
        test_train("d0_w0_p0_n2", 0, 0, 0, 2, 1'b0);
        test_train("w5_p2_n2", 0, 5, 2, 2, 1'b0);
        test_train("retrig_cfg_change", 2, 3, 10, 3, 1'b1);
        test_train("single_pulse", 0, 1, 1, 1, 1'b0);
        test_random();
        test_abort();
        test_zero_count();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pulse_train_gen

// File: doc/pulse_train_gen.md
PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

Interface
REQ-001 Parameter CNT_W, default 16: width of delay, width and period timing fields, in clock cycles.
REQ-002 Parameter NUM_W, default 8: width of the pulse-count field.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 trig  input  1  start request; only a rising edge is acted on.
REQ-006 abort  input  1  synchronous cancel of a running train.
REQ-007 cfg_delay  input  CNT_W  cycles from trigger acceptance to the first pulse, D.
REQ-008 cfg_width  input  CNT_W  high time per pulse, W.
REQ-009 cfg_period  input  CNT_W  rising-edge-to-rising-edge spacing, P.
REQ-010 cfg_count  input  NUM_W  pulses per train, N.
REQ-011 out  output  1  registered pulse-train output.
REQ-012 busy  output  1  high while a train is in progress.
REQ-013 done  output  1  one-cycle strobe when a train completes normally.

Function
REQ-014 The block SHALL accept a trigger at posedge k when trig=1 at k, the registered previous trig=0, and busy=0.
REQ-015 Triggers arriving while busy=1 SHALL be ignored.
REQ-016 cfg_* SHALL be latched at acceptance; changes during a train SHALL have no effect on it.
REQ-017 State machine states: IDLE, DELAY, HIGH, LOW.
  - IDLE->DELAY on acceptance when D>0; IDLE->HIGH when D=0.
  - DELAY->HIGH after D cycles.
  - HIGH->LOW after We cycles.
  - LOW->HIGH after Pe-We cycles while pulses remain; otherwise LOW->IDLE.
REQ-018 Effective width We=max(W,1); effective period Pe=max(P,We+1); pulses never merge.
REQ-019 Pulse i (0..N-1) SHALL set out=1 at posedge k+1+D+i*Pe and clear it at posedge k+1+D+i*Pe+We.
REQ-020 busy SHALL rise at posedge k and fall at the posedge where the last pulse clears; done SHALL be 1 for exactly the following cycle.
REQ-021 When N=0 with the macro absent: no pulse; busy=1 for one cycle from posedge k; done=1 in the cycle after posedge k+1.
REQ-022 abort=1 at any posedge SHALL, at that edge, force out=0, busy=0 and state IDLE, with no done strobe; abort SHALL take priority over trig on the same edge.
REQ-023 All counters SHALL be CNT_W/NUM_W wide, count down, never wrap, and saturate at maximum field values without overflow.

Reset
REQ-024 rst_n=0 SHALL immediately force out=0, busy=0, done=0, state=IDLE, counters=0 and registered trig=0, including mid-pulse.
REQ-025 trig held high through reset release SHALL count as a rising edge at the first posedge.

Configuration
REQ-026 Macro PULSE_TRAIN_GEN_CONTINUOUS_EN:
  - When defined, N=0 SHALL produce an endless train with period Pe, ended only by abort or reset, and done is never asserted.
  - When undefined, N=0 behaves per REQ-021.

Structure
REQ-027 Package pulse_train_gen_pkg SHALL hold the state enumeration and the default CNT_W/NUM_W constants.
REQ-028 Sub-module trig_edge_det SHALL register trig and produce the rising-edge strobe; all other logic stays in pulse_train_gen.

Verification
REQ-029 D=2, W=3, P=10, N=3, trigger accepted at posedge k -> out rises at k+3, k+13 and k+23, each pulse 3 cycles; busy falls at k+26; done=1 in the cycle after k+26.
REQ-030 D=0, W=0, P=0, N=2 -> We=1, Pe=2; out high in the cycles after posedges k+1 and k+3; done after k+4.
REQ-031 W=5, P=2, N=2, D=0 -> second pulse rises at posedge k+7; pulses are never merged.
REQ-032 Second trig edge during a train, plus cfg_width changed mid-train -> train timing unchanged; no extra pulses.
REQ-033 abort mid-HIGH on pulse 2 of 4 -> out=0 and busy=0 at that edge, no done; a new trigger afterwards starts a fresh train.
REQ-034 rst_n low mid-pulse -> out=0 immediately without a clock edge. With PULSE_TRAIN_GEN_CONTINUOUS_EN defined and N=0, W=1, P=4 -> 10 consecutive pulses 4 cycles apart until abort.
